// File: rtl/parallax_sequencer.sv
// parallax_sequencer: per-frame scroll scheduler for the parallax renderer.
// Holds the base scroll state (9-bit LFSR seed + 3-bit pixel phase) of up to
// four layers. On each frame_tick it walks the layers once and advances each
// by its programmed Q2.2 speed, then holds seeds stable until the next frame.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   frame_tick        one-cycle pulse per frame (vblank start)
//   cfg_valid/ready   speed write handshake; cfg_layer selects the layer,
//                     cfg_speed is unsigned Q2.2 pixels/frame
//   seed_lfsr         layer k seed at [9k+8:9k]
//   seed_phase        layer k phase at [3k+2:3k]
//   busy              update in progress
//   frame_done        one-cycle pulse in the final busy cycle
//   overrun           sticky, frame_tick seen while busy
module parallax_sequencer #(
   parameter int unsigned LAYERS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_tick,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [1:0]            cfg_layer,
   input  logic [3:0]            cfg_speed,
   output logic [9*LAYERS-1:0]   seed_lfsr,
   output logic [3*LAYERS-1:0]   seed_phase,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   localparam int unsigned      IDX_W    = (LAYERS > 2) ? 2 : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYERS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_STEP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       steps_q;
   logic             overrun_q;

   logic [8:0]       lfsr_q  [LAYERS];
   logic [2:0]       phase_q [LAYERS];
   logic [1:0]       frac_q  [LAYERS];
   logic [3:0]       speed_q [LAYERS];

   logic [4:0]       sum_d;
   logic             cfg_fire_d;
   logic             cfg_in_range_d;
   logic [IDX_W-1:0] cfg_idx_d;

   // Accumulator sum for the current layer and config write decode
   always_comb begin
      sum_d          = {3'b000, frac_q[idx_q]} + {1'b0, speed_q[idx_q]};
      cfg_fire_d     = cfg_valid & cfg_ready;
      cfg_in_range_d = (32'(cfg_layer) < LAYERS);
      cfg_idx_d      = IDX_W'(cfg_layer);
   end

   // Sequencer FSM and per-layer scroll state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         steps_q   <= 3'd0;
         overrun_q <= 1'b0;
         for (int unsigned k = 0; k < LAYERS; k++) begin
            lfsr_q[IDX_W'(k)]  <= 9'h1FF;
            phase_q[IDX_W'(k)] <= 3'd7;
            frac_q[IDX_W'(k)]  <= 2'd0;
            speed_q[IDX_W'(k)] <= 4'd0;
         end
      end else begin
         // A tick while an update is still running is dropped, not queued
         if (frame_tick && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end

         // Out-of-range layers complete the handshake but store nothing
         if (cfg_fire_d && cfg_in_range_d) begin
            speed_q[cfg_idx_d] <= cfg_speed;
         end

         unique case (state_q)
            S_IDLE: begin
               if (frame_tick) begin
                  idx_q   <= '0;
                  state_q <= S_ACCUM;
               end
            end

            S_ACCUM: begin
               steps_q        <= sum_d[4:2];
               frac_q[idx_q]  <= sum_d[1:0];
               if (sum_d[4:2] != 3'd0) begin
                  state_q <= S_STEP;
               end else if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= S_ACCUM;
               end
            end

            S_STEP: begin
               // LFSR shifts only when the phase wraps through zero
               if (phase_q[idx_q] == 3'd0) begin
                  lfsr_q[idx_q] <= {lfsr_q[idx_q][7:0], lfsr_q[idx_q][8] ^ lfsr_q[idx_q][4]};
               end
               phase_q[idx_q] <= phase_q[idx_q] + 3'd1;
               steps_q        <= steps_q - 3'd1;
               if (steps_q == 3'd1) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + IDX_W'(1);
                     state_q <= S_ACCUM;
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Status decoded straight from the state register
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign overrun    = overrun_q;
   assign cfg_ready  = (state_q == S_IDLE) & ~frame_tick;

   for (genvar k = 0; k < LAYERS; k++) begin : g_out
      assign seed_lfsr[9*k +: 9]  = lfsr_q[k];
      assign seed_phase[3*k +: 3] = phase_q[k];
   end

endmodule
